key_conditioner: RTL



---
 rtl/key_conditioner_pkg.sv | 20 ++
 rtl/key_conditioner_tick_gen.sv | 34 +++
 rtl/key_conditioner.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/key_conditioner_pkg.sv
// Shared types and sizing for the push-button conditioner: channel state
// encoding, counter widths and the prescaler period helper.
package key_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    HELD     = 3'd2,
    LONG     = 3'd3,
    REL_DB   = 3'd4
  } key_state_t;

  localparam int DB_W   = 8;
  localparam int HOLD_W = 16;

  function automatic int calc_tick_cyc(input int clk_hz, input int tick_us);
    return (clk_hz / 1000000) * tick_us;
  endfunction

endpackage

// File: rtl/key_conditioner_tick_gen.sv
// Shared prescaler: counts 0..TICK_CYC-1 and strobes tick on the last count,
// giving every key channel a common timing base.
module key_tick_gen #(
  parameter int TICK_CYC = 50000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYC - 1);

  logic [CW-1:0] r_cnt;
  logic          w_tick;

  if (TICK_CYC < 2) begin : g_bad_tick
    $error("key_tick_gen: TICK_CYC must be at least 2");
  end

  assign w_tick = (r_cnt == LAST);
  assign tick   = w_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// N-channel push-button conditioner: 2-FF sync, tick-based debounce, press/
// release/long pulses. Auto-repeat is built only with KEY_CONDITIONER_REPEAT_EN.
module key_conditioner
  import key_pkg::*;
#(
  parameter int NUM_KEYS       = 5,
  parameter int CLK_HZ         = 50000000,
  parameter int TICK_US        = 1000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int LONG_TICKS     = 1000,
  parameter int REPEAT_TICKS   = 100,
  parameter int ACTIVE_HIGH    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic                tick
);

  localparam int TICK_CYC = calc_tick_cyc(CLK_HZ, TICK_US);
  localparam logic [DB_W-1:0]     DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [HOLD_W-1:0]   LONG_LAST = HOLD_W'(LONG_TICKS - 1);
  localparam logic [NUM_KEYS-1:0] INV_MASK  = (ACTIVE_HIGH != 0) ? '0 : '1;
`ifdef KEY_CONDITIONER_REPEAT_EN
  localparam logic [HOLD_W-1:0]   REP_LAST  = HOLD_W'(REPEAT_TICKS - 1);
`endif

  if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 255) begin : g_bad_db
    $error("key_conditioner: DEBOUNCE_TICKS must be 1..255");
  end
  if (LONG_TICKS < 1 || LONG_TICKS > 65535) begin : g_bad_long
    $error("key_conditioner: LONG_TICKS must be 1..65535");
  end
  if (REPEAT_TICKS < 1 || REPEAT_TICKS > 65535) begin : g_bad_rep
    $error("key_conditioner: REPEAT_TICKS must be 1..65535");
  end

  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic                w_tick;
  logic [NUM_KEYS-1:0] r_sync_p0;
  logic [NUM_KEYS-1:0] r_sync_p1;
  logic [NUM_KEYS-1:0] w_s;

  key_tick_gen #(
    .TICK_CYC (TICK_CYC)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  assign tick = w_tick;

  // p0/p1: metastability synchroniser, polarity normalised so 1 = pressed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
    end else begin
      r_sync_p0 <= key_in;
      r_sync_p1 <= r_sync_p0;
    end
  end

  assign w_s = r_sync_p1 ^ INV_MASK;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_state_t        r_state;
    key_state_t        w_state_nx;
    logic [DB_W-1:0]   r_db;
    logic [DB_W-1:0]   w_db_nx;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nx;
    logic              r_from_long;
    logic              w_from_long_nx;
    logic              r_level;
    logic              r_press;
    logic              r_release;
    logic              r_long;
    logic              w_level_nx;
    logic              w_press_ev;
    logic              w_release_ev;
    logic              w_long_ev;
    logic              w_s_ch;
`ifdef KEY_CONDITIONER_REPEAT_EN
    logic              r_repeat;
    logic              w_repeat_ev;
`endif

    assign w_s_ch = w_s[g];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state     <= IDLE;
        r_db        <= '0;
        r_hold      <= '0;
        r_from_long <= 1'b0;
        r_level     <= 1'b0;
        r_press     <= 1'b0;
        r_release   <= 1'b0;
        r_long      <= 1'b0;
`ifdef KEY_CONDITIONER_REPEAT_EN
        r_repeat    <= 1'b0;
`endif
      end else begin
        r_state     <= w_state_nx;
        r_db        <= w_db_nx;
        r_hold      <= w_hold_nx;
        r_from_long <= w_from_long_nx;
        r_level     <= w_level_nx;
        r_press     <= enable & w_press_ev;
        r_release   <= enable & w_release_ev;
        r_long      <= enable & w_long_ev;
`ifdef KEY_CONDITIONER_REPEAT_EN
        r_repeat    <= enable & w_repeat_ev;
`endif
      end
    end

    always_comb begin
      w_state_nx     = r_state;
      w_db_nx        = r_db;
      w_hold_nx      = r_hold;
      w_from_long_nx = r_from_long;
      case (r_state)
        IDLE: begin
          if (w_s_ch) begin
            w_state_nx = PRESS_DB;
            w_db_nx    = '0;
          end
        end
        PRESS_DB: begin
          if (!w_s_ch) begin
            w_state_nx = IDLE;
          end else if (w_tick) begin
            if (r_db >= DB_LAST) begin
              w_state_nx     = HELD;
              w_hold_nx      = '0;
              w_from_long_nx = 1'b0;
            end else begin
              w_db_nx = r_db + 1'b1;
            end
          end
        end
        HELD: begin
          if (!w_s_ch) begin
            w_state_nx     = REL_DB;
            w_db_nx        = '0;
            w_from_long_nx = 1'b0;
          end else if (w_tick) begin
            if (r_hold >= LONG_LAST) begin
              w_state_nx = LONG;
              w_hold_nx  = '0;
            end else begin
              w_hold_nx = sat_inc(r_hold);
            end
          end
        end
        LONG: begin
          if (!w_s_ch) begin
            w_state_nx     = REL_DB;
            w_db_nx        = '0;
            w_from_long_nx = 1'b1;
          end
`ifdef KEY_CONDITIONER_REPEAT_EN
          else if (w_tick) begin
            w_hold_nx = (r_hold >= REP_LAST) ? '0 : sat_inc(r_hold);
          end
`endif
        end
        REL_DB: begin
          // A bounce back to pressed resumes where the hold left off
          if (w_s_ch) begin
            w_state_nx = r_from_long ? LONG : HELD;
          end else if (w_tick) begin
            if (r_db >= DB_LAST) begin
              w_state_nx = IDLE;
            end else begin
              w_db_nx = r_db + 1'b1;
            end
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end

    always_comb begin
      w_press_ev   = (r_state == PRESS_DB) && (w_state_nx == HELD);
      w_release_ev = (r_state == REL_DB)   && (w_state_nx == IDLE);
      w_long_ev    = (r_state == HELD)     && (w_state_nx == LONG);
      w_level_nx   = (w_state_nx == HELD) || (w_state_nx == LONG) ||
                     (w_state_nx == REL_DB);
`ifdef KEY_CONDITIONER_REPEAT_EN
      w_repeat_ev  = w_long_ev ||
                     ((r_state == LONG) && (w_state_nx == LONG) && w_tick &&
                      (r_hold >= REP_LAST));
`endif
    end

    assign key_level[g]   = r_level;
    assign key_press[g]   = r_press;
    assign key_release[g] = r_release;
    assign key_long[g]    = r_long;
`ifdef KEY_CONDITIONER_REPEAT_EN
    assign key_repeat[g]  = r_repeat;
`endif
  end

`ifndef KEY_CONDITIONER_REPEAT_EN
  assign key_repeat = '0;
`endif

endmodule
